// File: rtl/if_fetch_unit_pkg.sv
// Shared CPU fetch definitions: fetch-state encoding, instruction size, reset PC default.
package if_fetch_unit_pkg;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_e;

    localparam int unsigned INSTR_BYTES      = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage : if_fetch_unit_pkg

// File: rtl/if_fetch_unit_skid_buf.sv
// if_skid_buf: 2-entry output/skid queue toward the IF/ID register, with flush.
// Ports:
//   clk_i, rst_i          clock, synchronous active-low reset
//   flush_i               drop both entries (redirect)
//   push_i, push_pc_i,
//   push_instr_i          new fetched instruction
//   ready_i               downstream accepts the output entry
//   valid_o, pc_o,
//   instr_o               output register contents
module if_skid_buf #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic [ADDR_W-1:0] push_pc_i,
    input  logic [DATA_W-1:0] push_instr_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic [DATA_W-1:0] instr_o
);

    logic              skid_valid_q;
    logic [ADDR_W-1:0] skid_pc_q;
    logic [DATA_W-1:0] skid_instr_q;
    logic              out_free;

    assign out_free = !valid_o || ready_i;

    // Output slot refills from the skid first so ordering is preserved.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            valid_o      <= 1'b0;
            pc_o         <= '0;
            instr_o      <= '0;
            skid_valid_q <= 1'b0;
            skid_pc_q    <= '0;
            skid_instr_q <= '0;
        end else if (flush_i) begin
            valid_o      <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (out_free) begin
            if (skid_valid_q) begin
                valid_o      <= 1'b1;
                pc_o         <= skid_pc_q;
                instr_o      <= skid_instr_q;
                skid_valid_q <= push_i;
                skid_pc_q    <= push_pc_i;
                skid_instr_q <= push_instr_i;
            end else begin
                valid_o <= push_i;
                if (push_i) begin
                    pc_o    <= push_pc_i;
                    instr_o <= push_instr_i;
                end
            end
        end else if (push_i) begin
            skid_valid_q <= 1'b1;
            skid_pc_q    <= push_pc_i;
            skid_instr_q <= push_instr_i;
        end
    end

endmodule : if_skid_buf

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: fetch PC, imem req/ack handshake, redirect flush,
// and a 2-entry output queue with valid/ready backpressure.
// Ports:
//   clk_i, rst_i                      clock, synchronous active-low reset
//   next_pc_i, redirect_i             PC-source mux target and select
//   pc_plus4_o                        fetch PC + 4 (mux sequential input)
//   imem_req_o, imem_addr_o,
//   imem_ack_i, imem_rdata_i          instruction memory handshake
//   if_valid_o, if_pc_o, if_instr_o,
//   if_ready_i                        output toward the IF/ID register
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] next_pc_i,
    input  logic              redirect_i,
    output logic [ADDR_W-1:0] pc_plus4_o,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [DATA_W-1:0] imem_rdata_i,
    output logic              if_valid_o,
    output logic [ADDR_W-1:0] if_pc_o,
    output logic [DATA_W-1:0] if_instr_o,
    input  logic              if_ready_i
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic              out_free;
    logic              push;
    logic              flush;

    assign pc_plus4_o  = fetch_pc_q + ADDR_W'(INSTR_BYTES);
    assign imem_addr_o = req_addr_q;
    // Request is suppressed during reset so an abandoned request is never re-driven.
    assign imem_req_o  = rst_i && (state_q != HOLD);
    assign out_free    = !if_valid_o || if_ready_i;

    // Next-state / PC logic; redirect wins over ack, ready and buffering.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        push       = 1'b0;
        flush      = 1'b0;
        unique case (state_q)
            FETCH: begin
                if (redirect_i) begin
                    flush      = 1'b1;
                    fetch_pc_d = next_pc_i;
                    state_d    = imem_ack_i ? FETCH : DISCARD;
                end else if (imem_ack_i) begin
                    push       = 1'b1;
                    fetch_pc_d = pc_plus4_o;
                    if (!out_free) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redirect_i) begin
                    flush      = 1'b1;
                    fetch_pc_d = next_pc_i;
                    state_d    = FETCH;
                end else if (if_ready_i) begin
                    state_d = FETCH;
                end
            end
            DISCARD: begin
                if (redirect_i) begin
                    flush      = 1'b1;
                    fetch_pc_d = next_pc_i;
                end
                if (imem_ack_i) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
        // The stale request stays on the bus until acked; otherwise track the fetch PC.
        req_addr_d = (state_d == DISCARD) ? req_addr_q : fetch_pc_d;
    end

    // State, fetch PC and request address registers.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= FETCH;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
        end
    end

    if_skid_buf #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_skid_buf (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush),
        .push_i      (push),
        .push_pc_i   (fetch_pc_q),
        .push_instr_i(imem_rdata_i),
        .ready_i     (if_ready_i),
        .valid_o     (if_valid_o),
        .pc_o        (if_pc_o),
        .instr_o     (if_instr_o)
    );

endmodule : if_fetch_unit

// File: tb/tb_if_fetch_unit.sv
// Directed self-checking bench for if_fetch_unit.
module tb_if_fetch_unit;

    logic        clk;
    logic        rst;
    logic [31:0] next_pc;
    logic        redirect;
    logic [31:0] pc_plus4;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_ready;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] TAG = 32'hFFFF_0000;

    if_fetch_unit dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .next_pc_i   (next_pc),
        .redirect_i  (redirect),
        .pc_plus4_o  (pc_plus4),
        .imem_req_o  (imem_req),
        .imem_addr_o (imem_addr),
        .imem_ack_i  (imem_ack),
        .imem_rdata_i(imem_rdata),
        .if_valid_o  (if_valid),
        .if_pc_o     (if_pc),
        .if_instr_o  (if_instr),
        .if_ready_i  (if_ready)
    );

    // Memory model: the word at an address is that address xor TAG.
    assign imem_rdata = imem_addr ^ TAG;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        rst      = 1'b0;
        next_pc  = 32'h0;
        redirect = 1'b0;
        imem_ack = 1'b0;
        if_ready = 1'b0;

        // Reset held for 3 edges
        repeat (3) cyc();
        chk("rst_req",   32'(imem_req), 32'h0);
        chk("rst_valid", 32'(if_valid), 32'h0);
        chk("rst_pc",    if_pc,         32'h0);
        chk("rst_instr", if_instr,      32'h0);
        rst = 1'b1;
        #1;
        chk("rel_req",   32'(imem_req), 32'h1);
        chk("rel_addr",  imem_addr,     32'h0);
        chk("rel_plus4", pc_plus4,      32'h4);

        // Streaming, zero-wait memory
        imem_ack = 1'b1;
        if_ready = 1'b1;
        cyc();
        chk("st0_valid", 32'(if_valid), 32'h1);
        chk("st0_pc",    if_pc,         32'h0);
        chk("st0_instr", if_instr,      32'hFFFF_0000);
        chk("st0_addr",  imem_addr,     32'h4);
        cyc();
        chk("st1_pc",    if_pc,         32'h4);
        chk("st1_instr", if_instr,      32'hFFFF_0004);
        cyc();
        chk("st2_pc",    if_pc,         32'h8);
        cyc();
        chk("st3_pc",    if_pc,         32'hC);
        chk("st3_instr", if_instr,      32'hFFFF_000C);
        chk("st3_valid", 32'(if_valid), 32'h1);

        // Backpressure from a fresh reset
        rst = 1'b0;
        cyc();
        chk("rst2_valid", 32'(if_valid), 32'h0);
        rst      = 1'b1;
        if_ready = 1'b0;
        cyc();
        chk("bp0_pc",   if_pc,         32'h0);
        chk("bp0_req",  32'(imem_req), 32'h1);
        chk("bp0_addr", imem_addr,     32'h4);
        cyc();
        chk("bp1_req",   32'(imem_req), 32'h0);
        chk("bp1_pc",    if_pc,         32'h0);
        chk("bp1_plus4", pc_plus4,      32'hC);
        cyc();
        cyc();
        chk("bp3_req",   32'(imem_req), 32'h0);
        chk("bp3_valid", 32'(if_valid), 32'h1);
        chk("bp3_pc",    if_pc,         32'h0);
        if_ready = 1'b1;
        cyc();
        chk("bp4_pc",    if_pc,         32'h4);
        chk("bp4_instr", if_instr,      32'hFFFF_0004);
        chk("bp4_req",   32'(imem_req), 32'h1);
        chk("bp4_addr",  imem_addr,     32'h8);
        cyc();
        chk("bp5_pc",    if_pc,         32'h8);
        chk("bp5_instr", if_instr,      32'hFFFF_0008);

        // Reset while in HOLD with both entries full
        if_ready = 1'b0;
        cyc();
        chk("rh_req", 32'(imem_req), 32'h0);
        chk("rh_pc",  if_pc,         32'h8);
        rst = 1'b0;
        cyc();
        chk("rh_valid", 32'(if_valid), 32'h0);
        chk("rh_opc",   if_pc,         32'h0);
        chk("rh_instr", if_instr,      32'h0);
        chk("rh_plus4", pc_plus4,      32'h4);
        chk("rh_req0",  32'(imem_req), 32'h0);
        rst = 1'b1;
        #1;
        chk("rh_req1", 32'(imem_req), 32'h1);
        chk("rh_addr", imem_addr,     32'h0);

        // Redirect while waiting on an unacked request at 0x8
        if_ready = 1'b1;
        cyc();
        cyc();
        chk("rw_addr8", imem_addr, 32'h8);
        chk("rw_pc4",   if_pc,     32'h4);
        imem_ack = 1'b0;
        redirect = 1'b1;
        next_pc  = 32'h100;
        cyc();
        chk("rw_valid0", 32'(if_valid), 32'h0);
        chk("rw_req0",   32'(imem_req), 32'h1);
        chk("rw_old",    imem_addr,     32'h8);
        chk("rw_plus4",  pc_plus4,      32'h104);
        redirect = 1'b0;
        cyc();
        chk("rw_valid1", 32'(if_valid), 32'h0);
        chk("rw_old1",   imem_addr,     32'h8);
        imem_ack = 1'b1;
        cyc();
        chk("rw_valid2", 32'(if_valid), 32'h0);
        chk("rw_new",    imem_addr,     32'h100);
        cyc();
        chk("rw_valid3", 32'(if_valid), 32'h1);
        chk("rw_pc",     if_pc,         32'h100);
        chk("rw_instr",  if_instr,      32'hFFFF_0100);

        // Redirect coincident with ack
        redirect = 1'b1;
        next_pc  = 32'h10;
        cyc();
        chk("rc_valid0", 32'(if_valid), 32'h0);
        chk("rc_addr10", imem_addr,     32'h10);
        next_pc = 32'h40;
        cyc();
        chk("rc_valid1", 32'(if_valid), 32'h0);
        chk("rc_addr40", imem_addr,     32'h40);
        chk("rc_plus4",  pc_plus4,      32'h44);
        redirect = 1'b0;
        cyc();
        chk("rc_pc",    if_pc,    32'h40);
        chk("rc_instr", if_instr, 32'hFFFF_0040);

        // PC + 4 wrap-around
        imem_ack = 1'b0;
        redirect = 1'b1;
        next_pc  = 32'hFFFF_FFFC;
        cyc();
        redirect = 1'b0;
        chk("wrap_plus4", pc_plus4, 32'h0);
        imem_ack = 1'b1;
        cyc();
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        cyc();
        chk("wrap_pc",   if_pc,     32'hFFFF_FFFC);
        chk("wrap_addr2", imem_addr, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_if_fetch_unit
